id_ex_pipe_reg: RTL

- Parametrised decode→execute pipeline register, successor to the fixed-field ID/EX latch.
- Carries an opaque datapath bundle (PC, immediates, bus operands, register indices) and a control bundle (RegWr, MemWr, ALUOp, …).
- Adds valid/ready handshake with a 2-entry skid buffer, synchronous flush, and forced-zero control on bubbles.
- Adds saturating stall/bubble performance counters.

---
 rtl/id_ex_pipe_reg.sv | 113 +++++++++++
 1 files changed

// File: rtl/id_ex_pipe_reg.sv
// Decode-to-execute pipeline register with a 2-entry skid buffer, flush and
// bubble-masked control. Also keeps saturating stall/bubble counters. State changes on the falling clock edge.
module id_ex_pipe_reg #(
    parameter int DATA_W = 158,
    parameter int CTRL_W = 12,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [1:0]        dbg_state
);

    // Encoding is {main_valid, skid_valid}; (0,1) is unreachable.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_FULL1 = 2'b10,
        ST_FULL2 = 2'b11
    } state_e;

    state_e              state_q;
    logic [DATA_W-1:0]   main_data_q;
    logic [CTRL_W-1:0]   main_ctrl_q;
    logic [DATA_W-1:0]   skid_data_q;
    logic [CTRL_W-1:0]   skid_ctrl_q;
    logic [CNT_W-1:0]    stall_cnt_q;
    logic [CNT_W-1:0]    stall_cnt_d;
    logic [CNT_W-1:0]    bubble_cnt_q;
    logic [CNT_W-1:0]    bubble_cnt_d;
    logic                main_valid;

    assign main_valid = state_q[1];

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (main_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + 1'b1;
        if (!main_valid && out_ready && (bubble_cnt_q != {CNT_W{1'b1}}))
            bubble_cnt_d = bubble_cnt_q + 1'b1;
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_EMPTY;
            main_data_q  <= '0;
            main_ctrl_q  <= '0;
            skid_data_q  <= '0;
            skid_ctrl_q  <= '0;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
            if (flush) begin
                // Data registers keep their value; only the valid bits drop.
                state_q <= ST_EMPTY;
            end else begin
                case (state_q)
                    ST_EMPTY: begin
                        if (in_valid) begin
                            main_data_q <= in_data;
                            main_ctrl_q <= in_ctrl;
                            state_q     <= ST_FULL1;
                        end
                    end
                    ST_FULL1: begin
                        if (out_ready) begin
                            if (in_valid) begin
                                main_data_q <= in_data;
                                main_ctrl_q <= in_ctrl;
                            end else begin
                                state_q <= ST_EMPTY;
                            end
                        end else if (in_valid) begin
                            skid_data_q <= in_data;
                            skid_ctrl_q <= in_ctrl;
                            state_q     <= ST_FULL2;
                        end
                    end
                    ST_FULL2: begin
                        // in_ready is low here, so in_valid is ignored.
                        if (out_ready) begin
                            main_data_q <= skid_data_q;
                            main_ctrl_q <= skid_ctrl_q;
                            state_q     <= ST_FULL1;
                        end
                    end
                    default: state_q <= ST_EMPTY;
                endcase
            end
        end
    end

    assign in_ready   = (state_q != ST_FULL2);
    assign out_valid  = main_valid;
    assign out_data   = main_data_q;
    assign out_ctrl   = main_ctrl_q & {CTRL_W{main_valid}};
    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
    assign dbg_state  = state_q;

endmodule
